// File: rtl/contador_secuencia_prog.sv
// rtl/contador_secuencia_prog.sv - programmable-sequence counter over a writable table; optional macro CONT_DOWN_EN adds D and backward stepping
module contador_secuencia_prog #(
  parameter  int WIDTH = 4,
  parameter  int DEPTH = 8,
  localparam int IW    = (DEPTH > 2) ? $clog2(DEPTH) : 1
) (
  input  logic             C,
  input  logic             R,
  input  logic             EN,
`ifdef CONT_DOWN_EN
  input  logic             D,
`endif
  input  logic             LD,
  input  logic [IW-1:0]    LIDX,
  input  logic [IW-1:0]    LAST,
  input  logic             WE,
  input  logic [IW-1:0]    WA,
  input  logic [WIDTH-1:0] WD,
  output logic [WIDTH-1:0] Q,
  output logic [IW-1:0]    IDX,
  output logic             TC
);

  localparam logic [IW-1:0] MAX_IDX = IW'(DEPTH - 1);

  logic [IW-1:0]    r_idx;
  logic [WIDTH-1:0] r_table [DEPTH];

  logic [IW-1:0] w_last;
  logic          w_wa_ok;
  logic          w_fwd_term;
  logic          w_term;
  logic [IW-1:0] w_idx_nxt;

  // With a power-of-two depth every encodable LAST/WA is in range, so no clamp is built.
  generate
    if ((1 << IW) == DEPTH) begin : g_full
      assign w_last  = LAST;
      assign w_wa_ok = 1'b1;
    end else begin : g_partial
      assign w_last  = (LAST > MAX_IDX) ? MAX_IDX : LAST;
      assign w_wa_ok = (WA <= MAX_IDX);
    end
  endgenerate

  assign w_fwd_term = (r_idx >= w_last);

`ifdef CONT_DOWN_EN
  logic w_bwd_term;
  assign w_bwd_term = (r_idx == '0) || (r_idx > w_last);
  assign w_term     = D ? w_bwd_term : w_fwd_term;

  always_comb begin
    w_idx_nxt = r_idx;
    if (LD) begin
      w_idx_nxt = (LIDX <= w_last) ? LIDX : '0;
    end else if (EN) begin
      if (D) w_idx_nxt = w_bwd_term ? w_last : r_idx - IW'(1);
      else   w_idx_nxt = w_fwd_term ? '0 : r_idx + IW'(1);
    end
  end
`else
  assign w_term = w_fwd_term;

  always_comb begin
    w_idx_nxt = r_idx;
    if (LD) begin
      w_idx_nxt = (LIDX <= w_last) ? LIDX : '0;
    end else if (EN) begin
      w_idx_nxt = w_fwd_term ? '0 : r_idx + IW'(1);
    end
  end
`endif

  always_ff @(posedge C or posedge R) begin
    if (R) r_idx <= '0;
    else   r_idx <= w_idx_nxt;
  end

  always_ff @(posedge C or posedge R) begin
    if (R) begin
      for (int i = 0; i < DEPTH; i++) r_table[i] <= WIDTH'(i);
    end else if (WE && w_wa_ok) begin
      r_table[WA] <= WD;
    end
  end

  assign Q   = r_table[r_idx];
  assign IDX = r_idx;
  // R masks TC because LAST=0 makes index 0 terminal even while held in reset.
  assign TC  = EN & ~LD & w_term & ~R;

endmodule
